ycbcr_rgb_pipe: RTL and testbench
=================================

YCBCR_RGB_PIPE -- requirements
Module: ycbcr_rgb_pipe

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning input component width in bits.
REQ-002 The block SHALL have parameter FW, default 8, meaning fractional bits of outputs and coefficients.
REQ-003 The block SHALL have parameter MODE, default 0, meaning coefficient set: 0 = BT.601 full range, 1 = BT.709 full range.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data carries a component this cycle.
REQ-007 The block SHALL have port in_sop, input, 1 bit: qualified by in_valid, it marks the current byte as the Y of a new pixel.
REQ-008 The block SHALL have port in_data, input, DW bits: unsigned component, arriving serially in the order Y, Cb, Cr.
REQ-009 The block SHALL have ports R, G and B, each an output of DW+FW bits: unsigned fixed point with FW fractional bits.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking that new R/G/B values are present.
REQ-011 The block SHALL have port sync_err, output, 1 bit: a sticky flag for in_sop arriving mid-pixel.

Function
REQ-012 The block SHALL track components with a 3-state counter, S_Y -> S_CB -> S_CR -> S_Y, advancing only on cycles with in_valid=1.
REQ-013 The block SHALL hold the current state and the captured components on cycles with in_valid=0, so gaps are allowed between any components.
REQ-014 On in_valid=1 and in_sop=1, the block SHALL capture in_data as Y and go to S_CB, whatever the current state.
REQ-015 If in_sop=1 arrives while the state is not S_Y, the block SHALL set sync_err=1 and discard the partial pixel.
REQ-016 sync_err SHALL clear only on reset.
REQ-017 in_sop=1 in state S_Y SHALL be legal and SHALL NOT set sync_err.
REQ-018 The chroma offset SHALL be computed as d = C - 2^(DW-1), signed, for both Cb and Cr.
REQ-019 Each coefficient SHALL be quantised as round-to-nearest of coeff*2^FW; for FW=8 the results SHALL be as follows:
- MODE 0: kRcr=359, kGcb=88, kGcr=183, kBcb=454.
- MODE 1: kRcr=403, kGcb=48, kGcr=120, kBcb=475.
REQ-020 The output equations SHALL be, with sufficient signed internal width and no overflow:
- R = (Y<<FW) + kRcr*dCr
- G = (Y<<FW) - kGcb*dCb - kGcr*dCr
- B = (Y<<FW) + kBcb*dCb
REQ-021 Each result SHALL be clamped to the range [0, (2^DW-1)<<FW] before it is registered.
REQ-022 The pipeline SHALL have two stages:
- Stage 1 registers the products on the edge after the Cr-accepting edge.
- Stage 2 registers the sums, clamps, R/G/B and out_valid.
REQ-023 out_valid SHALL be high for exactly one cycle, two clock edges after the edge that accepted Cr.
REQ-024 R, G and B SHALL hold their values until the next out_valid.
REQ-025 The block SHALL sustain one pixel every 3 cycles, with back-to-back pixels overlapping in the pipeline without loss.
REQ-026 A Cr accepted while a previous pixel is in stage 1 or stage 2 SHALL NOT corrupt that pixel.
REQ-027 MODE SHALL be elaboration-time only; no runtime mode switching is provided.

Reset
REQ-028 While reset=0 at a rising edge, the block SHALL set the following on that edge:
- state = S_Y
- R = G = B = 0, out_valid = 0, sync_err = 0
- all pipeline valid bits cleared
REQ-029 A reset taken mid-pixel or mid-pipeline SHALL discard all partial data, produce no out_valid afterwards for that data, and treat the first valid byte after reset as Y.
REQ-030 reset SHALL take priority over in_valid on the same edge.

Verification
REQ-031 The bench SHALL cover a neutral pixel: MODE 0, Y/Cb/Cr = 128/128/128 -> R=G=B=16'h8000, with out_valid 2 edges after the Cr edge.
REQ-032 The bench SHALL cover a nominal pixel: MODE 0, 100/150/90 -> R=16'h2EB6, G=16'h779A, B=16'h8B04.
REQ-033 The bench SHALL cover clamping: MODE 0, 255/128/255 -> R=16'hFF00 (clamped high); and 0/0/128 -> R=0, B=0 (clamped low), G=16'h2C00.
REQ-034 The bench SHALL cover the coefficient set: MODE 1, 0/0/128 -> G=16'h1800, R=0, B=0.
REQ-035 The bench SHALL cover gaps and resync: send Y, Cb, then 2 idle cycles, then Cr, which yields a correct pixel; then send Y, Cb, then in_sop with Y -> sync_err=1, and the next Cb, Cr yield a pixel built from the new Y.
REQ-036 The bench SHALL cover reset: assert reset=0 after Y, Cb, then release -> outputs 0, no out_valid; the following 128/128/128 yields 16'h8000 on all three outputs.

Source files
------------

// File: rtl/ycbcr_rgb_pipe.sv
// Serial YCbCr (Y, Cb, Cr) to parallel fixed-point RGB converter.
// Two-stage pipeline: products, then sums with clamping.
module ycbcr_rgb_pipe #(
    parameter int DW   = 8,
    parameter int FW   = 8,
    parameter int MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic [DW-1:0]    in_data,
    output logic [DW+FW-1:0] R,
    output logic [DW+FW-1:0] G,
    output logic [DW+FW-1:0] B,
    output logic             out_valid,
    output logic             sync_err
);

    localparam int SW = DW + FW + 4;

    localparam real C_RCR = (MODE == 1) ? 1.5748   : 1.402;
    localparam real C_GCB = (MODE == 1) ? 0.187324 : 0.344136;
    localparam real C_GCR = (MODE == 1) ? 0.468124 : 0.714136;
    localparam real C_BCB = (MODE == 1) ? 1.8556   : 1.772;

    localparam logic signed [SW-1:0] K_RCR =
        SW'($rtoi(C_RCR * (2.0 ** FW) + 0.5));
    localparam logic signed [SW-1:0] K_GCB =
        SW'($rtoi(C_GCB * (2.0 ** FW) + 0.5));
    localparam logic signed [SW-1:0] K_GCR =
        SW'($rtoi(C_GCR * (2.0 ** FW) + 0.5));
    localparam logic signed [SW-1:0] K_BCB =
        SW'($rtoi(C_BCB * (2.0 ** FW) + 0.5));

    localparam logic signed [SW-1:0] MAXV =
        SW'({{DW{1'b1}}, {FW{1'b0}}});

    typedef enum logic [1:0] {
        S_Y  = 2'd0,
        S_CB = 2'd1,
        S_CR = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            w_cr_acc;
    logic            w_err_set;
    logic            w_y_cap;
    logic            w_cb_cap;

    logic [DW-1:0]   r_y;
    logic [DW-1:0]   r_cb;
    logic [DW-1:0]   r_py;
    logic [DW-1:0]   r_pcb;
    logic [DW-1:0]   r_pcr;
    logic            r_pv;

    logic signed [DW:0]   w_dcb;
    logic signed [DW:0]   w_dcr;
    logic signed [SW-1:0] w_ecb;
    logic signed [SW-1:0] w_ecr;

    logic signed [SW-1:0] r_s1_y;
    logic signed [SW-1:0] r_s1_rcr;
    logic signed [SW-1:0] r_s1_gcb;
    logic signed [SW-1:0] r_s1_gcr;
    logic signed [SW-1:0] r_s1_bcb;
    logic                 r_s1_v;

    logic signed [SW-1:0] w_sr;
    logic signed [SW-1:0] w_sg;
    logic signed [SW-1:0] w_sb;

    always_comb begin
        w_state_nx = r_state;
        w_cr_acc   = 1'b0;
        w_err_set  = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                w_state_nx = S_CB;
                w_err_set  = (r_state != S_Y);
            end else begin
                unique case (r_state)
                    S_Y:  w_state_nx = S_CB;
                    S_CB: w_state_nx = S_CR;
                    S_CR: begin
                        w_state_nx = S_Y;
                        w_cr_acc   = 1'b1;
                    end
                    default: w_state_nx = S_Y;
                endcase
            end
        end
    end

    assign w_y_cap  = in_valid && (in_sop || r_state == S_Y);
    assign w_cb_cap = in_valid && !in_sop && r_state == S_CB;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_Y;
            sync_err <= 1'b0;
            r_y      <= '0;
            r_cb     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_err_set) sync_err <= 1'b1;
            if (w_y_cap)   r_y      <= in_data;
            if (w_cb_cap)  r_cb     <= in_data;
        end
    end

    // Whole pixel is latched on the Cr edge so the next Y/Cb can overwrite r_y/r_cb.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_py  <= '0;
            r_pcb <= '0;
            r_pcr <= '0;
            r_pv  <= 1'b0;
        end else begin
            r_pv <= w_cr_acc;
            if (w_cr_acc) begin
                r_py  <= r_y;
                r_pcb <= r_cb;
                r_pcr <= in_data;
            end
        end
    end

    assign w_dcb = $signed({1'b0, r_pcb}) - $signed({2'b01, {(DW-1){1'b0}}});
    assign w_dcr = $signed({1'b0, r_pcr}) - $signed({2'b01, {(DW-1){1'b0}}});
    assign w_ecb = SW'(w_dcb);
    assign w_ecr = SW'(w_dcr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_y   <= '0;
            r_s1_rcr <= '0;
            r_s1_gcb <= '0;
            r_s1_gcr <= '0;
            r_s1_bcb <= '0;
            r_s1_v   <= 1'b0;
        end else begin
            r_s1_v <= r_pv;
            if (r_pv) begin
                r_s1_y   <= SW'({r_py, {FW{1'b0}}});
                r_s1_rcr <= K_RCR * w_ecr;
                r_s1_gcb <= K_GCB * w_ecb;
                r_s1_gcr <= K_GCR * w_ecr;
                r_s1_bcb <= K_BCB * w_ecb;
            end
        end
    end

    assign w_sr = r_s1_y + r_s1_rcr;
    assign w_sg = r_s1_y - r_s1_gcb - r_s1_gcr;
    assign w_sb = r_s1_y + r_s1_bcb;

    function automatic logic [DW+FW-1:0] clamp(input logic signed [SW-1:0] v);
        if (v < 0)         return '0;
        else if (v > MAXV) return MAXV[DW+FW-1:0];
        else               return v[DW+FW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            R         <= '0;
            G         <= '0;
            B         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_s1_v;
            if (r_s1_v) begin
                R <= clamp(w_sr);
                G <= clamp(w_sg);
                B <= clamp(w_sb);
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_rgb_pipe.sv
// Directed bench for ycbcr_rgb_pipe: BT.601 and BT.709 instances
// share one input stream; expectations are hand-computed constants.
module tb_ycbcr_rgb_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sop;
    logic [7:0]  in_data;
    logic [15:0] r0, g0, b0, r1, g1, b1;
    logic        ov0, ov1, se0, se1;

    int n_chk = 0;
    int n_fail = 0;

    logic [47:0] q0[$];
    logic [47:0] q1[$];

    typedef struct {
        logic [7:0]  y, cb, cr;
        logic [47:0] e0;
        logic [47:0] e1;
    } vec_t;

    vec_t tv[4];

    ycbcr_rgb_pipe #(.DW(8), .FW(8), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop),
        .in_data(in_data), .R(r0), .G(g0), .B(b0),
        .out_valid(ov0), .sync_err(se0)
    );

    ycbcr_rgb_pipe #(.DW(8), .FW(8), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop),
        .in_data(in_data), .R(r1), .G(g1), .B(b1),
        .out_valid(ov1), .sync_err(se1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ov0) q0.push_back({r0, g0, b0});
        if (ov1) q1.push_back({r1, g1, b1});
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic sop);
        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input int i);
        put(tv[i].y, 1'b1);
        put(tv[i].cb, 1'b0);
        put(tv[i].cr, 1'b0);
    endtask

    task automatic pop_chk(input string name, input int i);
        logic [47:0] a;
        if (q0.size() == 0) begin
            a = '0;
            chk({name, "_m0_missing"}, 64'd0, 64'd1);
        end else begin
            a = q0.pop_front();
            chk({name, "_m0"}, 64'(a), 64'(tv[i].e0));
        end
        if (q1.size() == 0) begin
            chk({name, "_m1_missing"}, 64'd0, 64'd1);
        end else begin
            a = q1.pop_front();
            chk({name, "_m1"}, 64'(a), 64'(tv[i].e1));
        end
    endtask

    initial begin
        tv[0] = '{8'd128, 8'd128, 8'd128,
                  {16'h8000, 16'h8000, 16'h8000},
                  {16'h8000, 16'h8000, 16'h8000}};
        tv[1] = '{8'd100, 8'd150, 8'd90,
                  {16'h2EB6, 16'h779A, 16'h8B04},
                  {16'h282E, 16'h71B0, 16'h8CD2}};
        tv[2] = '{8'd255, 8'd128, 8'd255,
                  {16'hFF00, 16'hA437, 16'hFF00},
                  {16'hFF00, 16'hC378, 16'hFF00}};
        tv[3] = '{8'd0, 8'd0, 8'd128,
                  {16'h0000, 16'h2C00, 16'h0000},
                  {16'h0000, 16'h1800, 16'h0000}};

        reset = 1'b0;
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_data = '0;
        idle(3);
        chk("reset_rgb", 64'({r0, g0, b0}), 64'd0);
        chk("reset_flags", 64'({ov0, se0, ov1, se1}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Latency: out_valid exactly two edges after the Cr edge, one cycle wide.
        pix(0);
        idle(1);
        chk("lat_edge1_valid", 64'(ov0), 64'd0);
        idle(1);
        chk("lat_edge2_valid", 64'({ov0, ov1}), 64'b11);
        chk("lat_edge2_rgb", 64'({r0, g0, b0}), 64'(tv[0].e0));
        idle(1);
        chk("lat_edge3_valid", 64'(ov0), 64'd0);
        chk("lat_hold_rgb", 64'({r0, g0, b0}), 64'(tv[0].e0));
        q0.delete();
        q1.delete();

        for (int i = 0; i < 4; i++) begin
            pix(i);
            idle(4);
            pop_chk($sformatf("vec%0d", i), i);
            chk($sformatf("vec%0d_extra", i), 64'(q0.size()), 64'd0);
        end

        // Back-to-back pixels overlapping in the pipeline.
        pix(1);
        pix(2);
        pix(3);
        idle(5);
        chk("b2b_count", 64'(q0.size()), 64'd3);
        pop_chk("b2b_a", 1);
        pop_chk("b2b_b", 2);
        pop_chk("b2b_c", 3);

        // Gap between Cb and Cr.
        put(8'd100, 1'b1);
        put(8'd150, 1'b0);
        idle(2);
        put(8'd90, 1'b0);
        idle(4);
        pop_chk("gap", 1);
        chk("gap_no_err", 64'({se0, se1}), 64'd0);

        // Resync: a new SOP mid-pixel restarts with the new Y.
        put(8'd50, 1'b1);
        put(8'd60, 1'b0);
        put(8'd128, 1'b1);
        chk("resync_err", 64'({se0, se1}), 64'b11);
        put(8'd128, 1'b0);
        put(8'd128, 1'b0);
        idle(4);
        chk("resync_count", 64'(q0.size()), 64'd1);
        pop_chk("resync_pix", 0);
        chk("resync_sticky", 64'(se0), 64'd1);

        // Reset mid-pixel after Y, Cb.
        put(8'd200, 1'b1);
        put(8'd30, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        chk("rst_rgb", 64'({r0, g0, b0, r1}), 64'd0);
        chk("rst_flags", 64'({ov0, se0, se1}), 64'd0);
        chk("rst_no_out", 64'(q0.size()), 64'd0);
        put(8'd128, 1'b0);
        put(8'd128, 1'b0);
        put(8'd128, 1'b0);
        idle(4);
        chk("rst_next_count", 64'(q0.size()), 64'd1);
        pop_chk("rst_next_pix", 0);

        // Reset mid-pipeline drops the in-flight pixel.
        pix(1);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        chk("rst_pipe_no_out", 64'(q0.size() + q1.size()), 64'd0);
        chk("rst_pipe_rgb", 64'({r0, g0, b0}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
